// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a universal shift register: parallel load, N shifts, capture.
// Build option SHIFT_SEQ_GAP_EN inserts a one-cycle hold (GAP) between consecutive shifts.
module shift_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic [CNT_W-1:0] in_count,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] parallel_in,
    input  logic [WIDTH-1:0] reg_q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_HOLD  = 2'b00;
    localparam logic [MODE_W-1:0] MODE_RIGHT = 2'b01;
    localparam logic [MODE_W-1:0] MODE_LEFT  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_LOAD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SHIFT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_GAP     = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               dir_q, dir_d;
    logic [MODE_W-1:0]  mode_q, mode_d;
    logic [WIDTH-1:0]   parallel_in_q, parallel_in_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;
    logic               accept_c;

    // State and registered outputs; outputs are computed from the next state so they
    // line up cycle-for-cycle with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            data_q        <= '0;
            dir_q         <= 1'b0;
            mode_q        <= MODE_HOLD;
            parallel_in_q <= '0;
            result_q      <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            in_ready_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            data_q        <= data_d;
            dir_q         <= dir_d;
            mode_q        <= mode_d;
            parallel_in_q <= parallel_in_d;
            result_q      <= result_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            in_ready_q    <= in_ready_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        dir_d         = dir_q;
        mode_d        = MODE_HOLD;
        parallel_in_d = parallel_in_q;
        result_d      = result_q;
        done_d        = 1'b0;
        busy_d        = 1'b0;
        in_ready_d    = 1'b0;
        accept_c      = in_valid && in_ready_q;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    data_d  = in_data;
                    dir_d   = in_dir;
                    cnt_d   = in_count;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = (cnt_q != '0) ? S_SHIFT : S_CAPTURE;
            end
            S_SHIFT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_CAPTURE;
                end else begin
`ifdef SHIFT_SEQ_GAP_EN
                    state_d = S_GAP;
`else
                    state_d = S_SHIFT;
`endif
                end
            end
            S_GAP: begin
                state_d = S_SHIFT;
            end
            S_CAPTURE: begin
                result_d = reg_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Mode for the coming cycle; GAP, CAPTURE and IDLE all hold.
        case (state_d)
            S_LOAD:  mode_d = MODE_LOAD;
            S_SHIFT: mode_d = dir_d ? MODE_LEFT : MODE_RIGHT;
            default: mode_d = MODE_HOLD;
        endcase

        parallel_in_d = data_d;
        busy_d        = (state_d != S_IDLE);
        in_ready_d    = (state_d == S_IDLE);
    end

    assign mode        = mode_q;
    assign parallel_in = parallel_in_q;
    assign result      = result_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign in_ready    = in_ready_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl driving a behavioural universal shift register.
// Honours SHIFT_SEQ_GAP_EN when the design is built with it.
module tb_shift_seq_ctrl;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 3;
`ifdef SHIFT_SEQ_GAP_EN
    localparam int RST_AT = 3;
`else
    localparam int RST_AT = 2;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_dir;
    logic [CNT_W-1:0] in_count;
    logic [1:0]       mode;
    logic [WIDTH-1:0] parallel_in;
    logic [WIDTH-1:0] reg_q;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] exp_res_q[$];
    logic [1:0]       exp_mode_q[$];
    int               exp_lat_q[$];

    always #5 clk = ~clk;

    shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_dir      (in_dir),
        .in_count    (in_count),
        .mode        (mode),
        .parallel_in (parallel_in),
        .reg_q       (reg_q),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    // Behavioural universal_reg: zero-fill shifts.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_q <= '0;
        end else begin
            case (mode)
                2'b01:   reg_q <= reg_q >> 1;
                2'b10:   reg_q <= reg_q << 1;
                2'b11:   reg_q <= parallel_in;
                default: reg_q <= reg_q;
            endcase
        end
    end

    function automatic logic [WIDTH-1:0] model_result(input logic [WIDTH-1:0] d,
                                                      input logic dr,
                                                      input logic [CNT_W-1:0] c);
        logic [WIDTH-1:0] r;
        r = d;
        for (int i = 0; i < int'(c); i++) r = dr ? (r << 1) : (r >> 1);
        return r;
    endfunction

    task automatic push_cmd(input logic [WIDTH-1:0] d, input logic dr, input logic [CNT_W-1:0] c);
        int n;
        n = 0;
        exp_res_q.push_back(model_result(d, dr, c));
        exp_mode_q.push_back(2'b11);
        n++;
        for (int i = 0; i < int'(c); i++) begin
            exp_mode_q.push_back(dr ? 2'b10 : 2'b01);
            n++;
`ifdef SHIFT_SEQ_GAP_EN
            if (i != int'(c) - 1) begin
                exp_mode_q.push_back(2'b00);
                n++;
            end
`endif
        end
        exp_mode_q.push_back(2'b00);
        n++;
        exp_lat_q.push_back(n);
    endtask

    // Called at the first falling edge after the accept edge; returns at the done cycle.
    task automatic watch_cmd(input string name, input logic [WIDTH-1:0] d);
        int               lat;
        int               waited;
        logic [WIDTH-1:0] exp_r;
        logic [1:0]       em;
        lat   = exp_lat_q.pop_front();
        exp_r = exp_res_q.pop_front();
        total++;
        if (parallel_in !== d) begin
            bad++;
            $display("FAIL %s parallel_in: got %b want %b", name, parallel_in, d);
        end
        for (int n = 0; n < lat; n++) begin
            em = exp_mode_q.pop_front();
            total++;
            if (mode !== em || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL %s cycle %0d: mode=%b busy=%b done=%b want mode=%b busy=1 done=0",
                         name, n, mode, busy, done, em);
            end
            @(negedge clk);
        end
        waited = 0;
        while (done !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (done !== 1'b1 || waited != 0) begin
            bad++;
            $display("FAIL %s done latency: done=%b after %0d extra cycles, want done=1 at accept+%0d",
                     name, done, waited, lat);
        end
        total++;
        if (result !== exp_r) begin
            bad++;
            $display("FAIL %s result: got %b want %b", name, result, exp_r);
        end
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s done cycle: busy=%b in_ready=%b want busy=0 in_ready=1", name, busy, in_ready);
        end
    endtask

    task automatic test_cmd(input string name, input logic [WIDTH-1:0] d, input logic dr,
                            input logic [CNT_W-1:0] c);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dr;
        in_count = c;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
        end
        push_cmd(d, dr, c);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        watch_cmd(name, d);
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s done pulse width: got %b want 0", name, done);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({mode, parallel_in, result, done, busy, in_ready} !== {2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_held: mode=%b pin=%b res=%b done=%b busy=%b rdy=%b want 00 0000 0000 0 0 1",
                     mode, parallel_in, result, done, busy, in_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({mode, parallel_in, result, done, busy, in_ready} !== {2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_released: mode=%b pin=%b res=%b done=%b busy=%b rdy=%b want 00 0000 0000 0 0 1",
                     mode, parallel_in, result, done, busy, in_ready);
        end
    endtask

    task automatic test_reset_mid_cmd();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b0110;
        in_dir   = 1'b0;
        in_count = 3'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (RST_AT) @(negedge clk);
        total++;
        if (mode !== 2'b01 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset second shift: mode=%b busy=%b want mode=01 busy=1", mode, busy);
        end
        reset = 1'b1;
        #1;
        total++;
        if (mode !== 2'b00 || busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset async: mode=%b busy=%b rdy=%b done=%b want 00 0 1 0",
                     mode, busy, in_ready, done);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset aftermath %0d: done=%b busy=%b want 0 0", i, done, busy);
            end
        end
        test_cmd("after_reset", 4'b0101, 1'b0, 3'd1);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b1100;
        in_dir   = 1'b0;
        in_count = 3'd2;
        push_cmd(4'b1100, 1'b0, 3'd2);
        @(posedge clk);
        @(negedge clk);
        // Next command presented at once and held high through the busy period.
        in_data  = 4'b0011;
        in_dir   = 1'b1;
        in_count = 3'd3;
        push_cmd(4'b0011, 1'b1, 3'd3);
        watch_cmd("b2b_first", 4'b1100);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        watch_cmd("b2b_second", 4'b0011);
        @(negedge clk);
        total++;
        if (done !== 1'b0 || mode !== 2'b00) begin
            bad++;
            $display("FAIL b2b tail: done=%b mode=%b want done=0 mode=00", done, mode);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_dir   = 1'b0;
        in_count = '0;
        test_reset();
        test_cmd("right_by_2", 4'b1100, 1'b0, 3'd2);
        test_cmd("left_by_1", 4'b1011, 1'b1, 3'd1);
        test_cmd("count_zero", 4'b1100, 1'b0, 3'd0);
        test_cmd("count_max_zero_fill", 4'b1111, 1'b1, 3'd7);
        test_cmd("right_by_3", 4'b1001, 1'b0, 3'd3);
        test_reset_mid_cmd();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
